// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : serial_add_ctrl                                            |
// | Description : Bit-serial adder controller. One 1-bit full-add slice,     |
// |               built from two half adders and an OR, is reused for WIDTH  |
// |               cycles to add two WIDTH-bit operands LSB first. A          |
// |               start/busy/done handshake faces the ALU sequencer.         |
// | Options     : define SERIAL_ADD_SUB_EN to add the sub_i port, which      |
// |               selects A-B (B inverted on load, initial carry 1).         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_i,
`endif
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    // Bit counter only needs to reach WIDTH-1; it is cleared on every accept.
    localparam int                 c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    // Only WIDTH-1 earlier bits are stored; the last bit goes straight to sum_o.
    logic [WIDTH-2:0]   r_res_sh;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_sub;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_carry_init;

    logic               w_ha0_s;
    logic               w_ha0_c;
    logic               w_ha1_s;
    logic               w_ha1_c;
    logic               w_cout;

    logic [WIDTH-2:0]   w_res_shift;
    logic [WIDTH-1:0]   w_res_final;

`ifdef SERIAL_ADD_SUB_EN
    assign w_sub = sub_i;
`else
    assign w_sub = 1'b0;
`endif

    // Operand B and the initial carry as loaded on the accept edge.
    always_comb begin
        w_b_load     = w_sub ? ~b_i : b_i;
        w_carry_init = w_sub;
    end

    // Shared 1-bit full-add slice: two half adders, carries merged with OR.
    always_comb begin
        w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
        w_ha0_c = r_a_sh[0] & r_b_sh[0];
        w_ha1_s = w_ha0_s ^ r_carry;
        w_ha1_c = w_ha0_s & r_carry;
        w_cout  = w_ha0_c | w_ha1_c;
    end

    // Result register shifts right with the new sum bit entering at the top.
    generate
        if (WIDTH > 2) begin : g_res_wide
            assign w_res_shift = {w_ha1_s, r_res_sh[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign w_res_shift = w_ha1_s;
        end
    endgenerate

    // Full result including the bit produced on the final RUN edge.
    assign w_res_final = {w_ha1_s, r_res_sh};

    // Sequencer: accept, WIDTH serial steps, one-cycle done, back to idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            sum_o    <= '0;
            carry_o  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        // sum_o/carry_o keep the previous result until DONE.
                        r_a_sh  <= a_i;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_carry_init;
                        r_cnt   <= '0;
                        busy_o  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end

                ST_RUN: begin
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_res_sh <= w_res_shift;
                    r_carry  <= w_cout;
                    r_cnt    <= r_cnt + c_cnt_one;
                    if (r_cnt == c_cnt_last) begin
                        sum_o   <= w_res_final;
                        carry_o <= w_cout;
                        busy_o  <= 1'b0;
                        done_o  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_serial_add_ctrl                                         |
// | Description : Self-checking bench for serial_add_ctrl (WIDTH=16).        |
// |               Table vectors, handshake corner sequences and random ops   |
// |               compared against an arithmetic reference model.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_serial_add_ctrl;

    localparam int WIDTH = 16;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit c_sub_en = 1'b1;
`else
    localparam bit c_sub_en = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic             sub_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] sum_o;
    logic             carry_o;

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [WIDTH-1:0] r_prev_sum;
    logic             r_prev_carry;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             carry;
    } vec_t;

    vec_t vecs[$];

    always #5 clk_i = ~clk_i;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
`ifdef SERIAL_ADD_SUB_EN
        .sub_i   (sub_i),
`endif
        .a_i     (a_i),
        .b_i     (b_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
        .carry_o (carry_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Reference: plain modular arithmetic; carry = overflow, or no-borrow for subtract.
    function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic sub);
        longint unsigned ua, ub, m;
        ua = a;
        ub = b;
        m  = 64'd1 << WIDTH;
        if (sub && c_sub_en)
            return {(ua >= ub) ? 1'b1 : 1'b0, WIDTH'((ua + m - ub) % m)};
        return (WIDTH+1)'(ua + ub);
    endfunction

    // One full transaction from IDLE; operands are scrambled right after accept.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic sub, input logic [WIDTH-1:0] exp_sum,
                          input logic exp_carry, input string tag);
        int busy_cnt;
        bit held_ok;
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        sub_i   = sub;
        step();
        start_i  = 1'b0;
        a_i      = WIDTH'($urandom);
        b_i      = WIDTH'($urandom);
        sub_i    = ~sub;
        busy_cnt = 0;
        held_ok  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (busy_o && !done_o) busy_cnt++;
            if (sum_o !== r_prev_sum || carry_o !== r_prev_carry) held_ok = 1'b0;
            step();
        end
        check({tag, "_busy_len"}, 64'(busy_cnt), 64'(WIDTH));
        check({tag, "_hold"}, 64'(held_ok), 64'd1);
        check({tag, "_done"}, {62'd0, busy_o, done_o}, 64'b01);
        check({tag, "_sum"}, 64'(sum_o), 64'(exp_sum));
        check({tag, "_carry"}, 64'(carry_o), 64'(exp_carry));
        r_prev_sum   = exp_sum;
        r_prev_carry = exp_carry;
        step();
        check({tag, "_idle"}, {62'd0, busy_o, done_o}, 64'b00);
    endtask

    initial begin
        int          done_cnt;
        int          last_t;
        bit          ok_a;
        bit          ok_b;
        logic [WIDTH-1:0] got_sum;
        logic        got_carry;
        logic [WIDTH:0] exp;
        logic [WIDTH-1:0] ra, rb;
        logic        rs;

        rst_i   = 1'b1;
        start_i = 1'b0;
        sub_i   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) step();
        check("reset_state", {carry_o, busy_o, done_o, 45'd0, sum_o}, 64'd0);
        rst_i        = 1'b0;
        r_prev_sum   = '0;
        r_prev_carry = 1'b0;

        // Fixed vectors with hand-derived results
        vecs.push_back('{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0});
        vecs.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0});
        vecs.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0});
        vecs.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1});
        vecs.push_back('{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1});
        vecs.push_back('{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0});
        vecs.push_back('{16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1});
        vecs.push_back('{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1});
`endif
        foreach (vecs[k])
            run_op(vecs[k].a, vecs[k].b, vecs[k].sub, vecs[k].sum, vecs[k].carry,
                   $sformatf("vec%0d", k));

        // start_i pulse and operand change in the middle of RUN are ignored
        start_i = 1'b1;
        a_i     = 16'h1234;
        b_i     = 16'h4321;
        sub_i   = 1'b0;
        step();
        start_i = 1'b0;
        repeat (4) step();
        start_i = 1'b1;
        a_i     = 16'hAAAA;
        b_i     = 16'h5555;
        step();
        start_i   = 1'b0;
        done_cnt  = 0;
        got_sum   = '0;
        got_carry = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done_o) begin
                done_cnt++;
                got_sum   = sum_o;
                got_carry = carry_o;
            end
            step();
        end
        check("midrun_done_cnt", 64'(done_cnt), 64'd1);
        check("midrun_sum", 64'(got_sum), 64'h5555);
        check("midrun_carry", 64'(got_carry), 64'd0);
        check("midrun_no_restart", 64'(busy_o), 64'd0);
        r_prev_sum   = 16'h5555;
        r_prev_carry = 1'b0;

        // Reset at cycle 8 of RUN aborts with no done pulse
        start_i = 1'b1;
        a_i     = 16'hFFFF;
        b_i     = 16'h0001;
        step();
        start_i = 1'b0;
        repeat (7) step();
        rst_i   = 1'b1;
        start_i = 1'b1;
        step();
        check("abort_state", {carry_o, busy_o, done_o, 45'd0, sum_o}, 64'd0);
        rst_i   = 1'b0;
        start_i = 1'b0;
        ok_a    = 1'b1;
        for (int i = 0; i < WIDTH + 4; i++) begin
            if (done_o || busy_o) ok_a = 1'b0;
            step();
        end
        check("abort_quiet", 64'(ok_a), 64'd1);
        r_prev_sum   = '0;
        r_prev_carry = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "after_abort");

        // Reset dominates start in IDLE; nothing is queued
        rst_i   = 1'b1;
        start_i = 1'b1;
        step();
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("rst_over_start", {carry_o, busy_o, done_o, 45'd0, sum_o}, 64'd0);
        step();
        check("no_queued_start", 64'(busy_o), 64'd0);
        r_prev_sum   = '0;
        r_prev_carry = 1'b0;

        // Continuous start: one result every WIDTH+2 cycles
        start_i  = 1'b1;
        a_i      = 16'h00FF;
        b_i      = 16'h0001;
        sub_i    = 1'b0;
        done_cnt = 0;
        last_t   = -1;
        ok_a     = 1'b1;
        ok_b     = 1'b1;
        for (int cyc = 0; cyc < 4 * (WIDTH + 2) + 4 && done_cnt < 4; cyc++) begin
            step();
            if (busy_o && done_o) ok_b = 1'b0;
            if (done_o) begin
                if (sum_o !== 16'h0100 || carry_o !== 1'b0) ok_b = 1'b0;
                if (last_t >= 0 && cyc - last_t != WIDTH + 2) ok_a = 1'b0;
                last_t = cyc;
                done_cnt++;
            end
        end
        start_i = 1'b0;
        check("cont_done_cnt", 64'(done_cnt), 64'd4);
        check("cont_period", 64'(ok_a), 64'd1);
        check("cont_result", 64'(ok_b), 64'd1);
        repeat (2) step();
        check("cont_idle", {62'd0, busy_o, done_o}, 64'b00);
        r_prev_sum   = 16'h0100;
        r_prev_carry = 1'b0;

        // Random operations against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom_range(0, 1));
            if (n % 10 == 0) ra = '1;
            if (n % 10 == 5) rb = '0;
            exp = ref_model(ra, rb, rs);
            run_op(ra, rb, rs, exp[WIDTH-1:0], exp[WIDTH], $sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
